mul_iter: RTL and testbench

MUL_ITER -- requirements
Module: mul_iter

---
 rtl/mul_iter.sv | 228 ++++++++++++++++++++++
 tb/tb_mul_iter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_iter.sv
// -----------------------------------------------------------------------------
// mul_iter -- iterative shift-and-add multiplier (one partial product per cycle)
//
// Implements the four RISC-V M multiply flavours on NUM-bit operands. Signed
// operands are converted to magnitudes on accept. NUM add/shift cycles build
// the unsigned 2*NUM-bit product. One extra cycle negates the product when the
// operand signs differ. The result is then held until the consumer takes it.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request present on op/a/b
//   in_ready   out  block is idle and can accept a request
//   op[1:0]    in   00 MUL, 01 MULH (s x s), 10 MULHSU (s x u), 11 MULHU (u x u)
//   a[NUM-1:0] in   multiplicand (rs1)
//   b[NUM-1:0] in   multiplier (rs2)
//   out_valid  out  result valid
//   out_ready  in   consumer takes the result
//   result     out  low product half for MUL, high half otherwise; 0 when idle
//   busy       out  high whenever an operation is in flight
//
// Also contains cla_adder, the carry-lookahead adder used for the partial sums.
// -----------------------------------------------------------------------------

// cla_adder -- W-bit carry-lookahead adder, no carry in or out.
//   ST = "BK"     : Brent-Kung parallel-prefix carry network
//   ST = other    : "hybird" -- 4-bit lookahead groups, group carries rippled
module cla_adder #(
   parameter int    W  = 33,
   parameter string ST = "hybird"
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum
);

   // Brent-Kung: an up-sweep builds prefixes at bit 2^k-1 positions, then a
   // down-sweep fills in the remaining positions from those.
   function automatic logic [W-1:0] add_bk(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] g;
      logic [W-1:0] p;
      logic [W-1:0] p0;
      g  = x & y;
      p  = x ^ y;
      p0 = p;
      for (int d = 1; d < W; d = d * 2) begin
         for (int i = 2 * d - 1; i < W; i = i + 2 * d) begin
            g[i] = g[i] | (p[i] & g[i-d]);
            p[i] = p[i] & p[i-d];
         end
      end
      for (int d = 1 << $clog2(W); d >= 1; d = d / 2) begin
         for (int i = 3 * d - 1; i < W; i = i + 2 * d) begin
            g[i] = g[i] | (p[i] & g[i-d]);
            p[i] = p[i] & p[i-d];
         end
      end
      // g[i] is now the carry out of bit i, i.e. the carry into bit i+1
      return p0 ^ {g[W-2:0], 1'b0};
   endfunction

   // Hybrid: every carry inside a 4-bit group is looked ahead from the group
   // carry-in; group carry-outs ripple into the next group.
   function automatic logic [W-1:0] add_hybrid(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] g;
      logic [W-1:0] p;
      logic [W:0]   c;
      logic         gg;
      logic         gp;
      g    = x & y;
      p    = x ^ y;
      c    = '0;
      for (int s = 0; s < W; s = s + 4) begin
         gg = 1'b0;
         gp = 1'b1;
         for (int i = s; (i < s + 4) && (i < W); i++) begin
            gg     = g[i] | (p[i] & gg);
            gp     = gp & p[i];
            c[i+1] = gg | (gp & c[s]);
         end
      end
      return p ^ c[W-1:0];
   endfunction

   if (ST == "BK") begin : g_bk
      assign sum = add_bk(a, b);
   end else begin : g_hybrid
      assign sum = add_hybrid(a, b);
   end

endmodule

module mul_iter #(
   parameter int    NUM = 32,
   parameter string ST  = "hybird"
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [1:0]     op,
   input  logic [NUM-1:0] a,
   input  logic [NUM-1:0] b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [NUM-1:0] result,
   output logic           busy
);

   localparam int CW = $clog2(NUM + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     op_q,    op_d;
   logic           neg_q,   neg_d;
   logic [NUM-1:0] mcand_q, mcand_d;
   logic [NUM-1:0] hi_q,    hi_d;
   logic [NUM-1:0] lo_q,    lo_d;
   logic [CW-1:0]  count_q, count_d;

   logic           sa;
   logic           sb;
   logic [NUM:0]   add_a;
   logic [NUM:0]   add_b;
   logic [NUM:0]   sum;

   // Partial sum: the extra top bit keeps the carry, which shifts into hi.
   assign add_a = {1'b0, hi_q};
   assign add_b = lo_q[0] ? {1'b0, mcand_q} : '0;

   cla_adder #(
      .W  (NUM + 1),
      .ST (ST)
   ) u_add (
      .a   (add_a),
      .b   (add_b),
      .sum (sum)
   );

   // Operand signs only matter for the signed flavours: a for MULH/MULHSU,
   // b for MULH only.
   assign sa = a[NUM-1] & ((op == 2'b01) | (op == 2'b10));
   assign sb = b[NUM-1] & (op == 2'b01);

   // NOTE: every variable driven here gets its default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      neg_d   = neg_q;
      mcand_d = mcand_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      count_d = count_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d    = op;
               neg_d   = sa ^ sb;
               // Negating the most negative value wraps to itself, which read
               // as unsigned is exactly its magnitude 2^(NUM-1).
               mcand_d = sa ? (~a + NUM'(1)) : a;
               lo_d    = sb ? (~b + NUM'(1)) : b;
               hi_d    = '0;
               count_d = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            // {hi,lo} <= {sum,lo} >> 1: multiplier bits leave lo from the
            // bottom while product bits enter it from the top.
            hi_d    = sum[NUM:1];
            lo_d    = {sum[0], lo_q[NUM-1:1]};
            count_d = count_q + CW'(1);
            if (count_q == CW'(NUM - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            if (neg_q) begin
               {hi_d, lo_d} = ~{hi_q, lo_q} + (2 * NUM)'(1);
            end
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         neg_q   <= 1'b0;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         count_q <= count_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = out_valid ? ((op_q == 2'b00) ? lo_q : hi_q) : '0;

endmodule

// File: tb/tb_mul_iter.sv
// -----------------------------------------------------------------------------
// tb_mul_iter -- scoreboard bench for mul_iter (NUM = 32)
//
// The driver issues directed requests and pushes each hand-computed result,
// with its accept cycle, into a queue. The monitor samples just after each
// falling edge. It pops and compares on every out_valid & out_ready handshake.
// It also checks the first-valid latency and that result is 0 while idle.
// -----------------------------------------------------------------------------
module tb_mul_iter;

   localparam int NUM = 32;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [1:0]     op;
   logic [NUM-1:0] a;
   logic [NUM-1:0] b;
   logic           out_valid;
   logic           out_ready;
   logic [NUM-1:0] result;
   logic           busy;

   mul_iter #(
      .NUM (NUM),
      .ST  ("hybird")
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [NUM-1:0] exp;
      int             acc;
      string          name;
   } sb_t;

   typedef struct {
      logic [1:0]     op;
      logic [NUM-1:0] a;
      logic [NUM-1:0] b;
      logic [NUM-1:0] exp;
      string          name;
   } vec_t;

   sb_t  sb_q[$];
   vec_t vecs[16];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the accept.
   task automatic send(input logic [1:0] v_op, input logic [NUM-1:0] v_a,
                       input logic [NUM-1:0] v_b, input logic [NUM-1:0] v_exp,
                       input string name, output int acc);
      int guard;
      sb_t e;
      in_valid = 1'b1;
      op       = v_op;
      a        = v_a;
      b        = v_b;
      guard    = 0;
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      acc = -1;
      if (!in_ready) begin
         check({"accept_timeout_", name}, 32'(in_ready), 32'd1);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         acc    = cyc;
         e.exp  = v_exp;
         e.acc  = acc;
         e.name = name;
         sb_q.push_back(e);
         @(negedge clk);
         in_valid = 1'b0;
         op       = 2'($urandom_range(0, 3));
         a        = $urandom;
         b        = $urandom;
      end
   endtask

   task automatic drain();
      int guard = 0;
      while (sb_q.size() != 0 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (sb_q.size() != 0) check("drain_timeout", 32'(sb_q.size()), 32'd0);
   endtask

   // Monitor / scoreboard checker.
   initial begin
      bit seen = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (!out_valid) begin
            check("result_zero_when_invalid", result, 32'd0);
            seen = 1'b0;
         end else if (sb_q.size() == 0) begin
            check("unexpected_out_valid", 32'(out_valid), 32'd0);
         end else begin
            if (!seen) begin
               seen = 1'b1;
               check({"latency_", sb_q[0].name}, 32'(cyc + 1 - sb_q[0].acc), 32'(NUM + 2));
            end
            if (out_ready) begin
               check(sb_q[0].name, result, sb_q[0].exp);
               void'(sb_q.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got t=%0t, expected completion", $time);
      $fatal(1);
   end

   initial begin
      int acc;
      int prev;
      int guard;
      logic [NUM-1:0] held;

      vecs[0]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_x_m3"};
      vecs[1]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min_x_min"};
      vecs[2]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1_x_max"};
      vecs[3]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max_x_max"};
      vecs[4]  = '{2'b00, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "mul_0_x_m1"};
      vecs[5]  = '{2'b01, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_1_x_m1"};
      vecs[6]  = '{2'b11, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, "mulhu_1_x_max"};
      vecs[7]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_m1_x_m1"};
      vecs[8]  = '{2'b01, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "mulh_min_x_1"};
      vecs[9]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "mulhsu_min_x_max"};
      vecs[10] = '{2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulhu_2p31_sq"};
      vecs[11] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1_x_m1"};
      vecs[12] = '{2'b10, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001, "mulhsu_2_x_2p31"};
      vecs[13] = '{2'b01, 32'h0000_0002, 32'h8000_0000, 32'hFFFF_FFFF, "mulh_2_x_min"};
      vecs[14] = '{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, "mul_shift4_lo"};
      vecs[15] = '{2'b11, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, "mulhu_shift4_hi"};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      op        = 2'b00;
      a         = '0;
      b         = '0;
      out_ready = 1'b1;

      // Reset state.
      repeat (3) @(negedge clk);
      #1;
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result",    result,         32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Back-to-back directed vectors, one result every NUM+3 cycles.
      prev = -1;
      for (int i = 0; i < 16; i++) begin
         send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name, acc);
         if (prev >= 0 && acc >= 0) check("throughput", 32'(acc - prev), 32'(NUM + 3));
         prev = acc;
      end
      drain();

      // Backpressure: hold out_ready low for 5 cycles in DONE.
      out_ready = 1'b0;
      held      = 32'h2345_6780;
      send(2'b00, 32'h1234_5678, 32'h0000_0010, held, "mul_backpressure", acc);
      guard = 0;
      while (!out_valid && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         op       = 2'b11;
         a        = $urandom;
         b        = $urandom;
         #1;
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_result",    result,         held);
         check("bp_in_ready",  32'(in_ready),  32'd0);
         @(negedge clk);
      end
      // Handshake cycle, with in_valid still high: must not be accepted.
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("bp_idle_in_ready", 32'(in_ready), 32'd1);
      check("bp_idle_busy",     32'(busy),     32'd0);
      drain();

      // Asynchronous reset in the middle of CALC (count == 10).
      send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "aborted", acc);
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      check("async_rst_in_ready",  32'(in_ready),  32'd1);
      check("async_rst_busy",      32'(busy),      32'd0);
      check("async_rst_out_valid", 32'(out_valid), 32'd0);
      check("async_rst_result",    result,         32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      // No stale result may appear after release; the monitor flags any.
      repeat (40) @(negedge clk);
      send(2'b11, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, "post_rst_mulhu_3x5", acc);
      send(2'b00, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, "post_rst_mul_3x5", acc);
      drain();

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
